tile_scheduler: RTL and testbench
=================================

# tile_scheduler

Command-level sequencer that drives the tile processor's start/done handshake. It accepts one host command (operation plus tile-grid size) and walks the grid in row-major order, presenting `tile_i`/`tile_j`/`op_code` and pulsing `start` once per tile. For each tile it waits for the done event and guards it with a watchdog. At the end it raises a completion interrupt with a status code. It sits between the host/CSR layer and the tile processor.

## Interface
- `TIMEOUT_CYCLES`, default 4096: maximum number of WAIT cycles per tile before the timeout abort.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `cmd_valid` input 1: host command valid.
- `cmd_ready` output 1: high iff state is IDLE.
- `cmd_op` input 3: operation; 0 MUL, 1 ADD, 2 SUB, 3 CONV, 4 DOT.
- `cmd_rows_m1` input 3: number of tile rows minus 1.
- `cmd_cols_m1` input 3: number of tile columns minus 1.
- `cmd_abort` input 1: request to stop after the current tile.
- `tp_start` output 1: start pulse to the tile processor.
- `tp_tile_i` output 3: current tile row.
- `tp_tile_j` output 3: current tile column.
- `tp_op_code` output 3: latched operation.
- `tp_done` input 1: tile processor done level.
- `busy` output 1: high whenever state is not IDLE.
- `done_irq` output 1: one-cycle completion pulse.
- `status` output 2: 0 OK, 1 TIMEOUT, 2 BAD_OP, 3 ABORTED; valid from `done_irq` until the next accept.
- `tiles_done` output 7: number of tiles completed in the current/last command (0..64).

## Operation
- States:
  - IDLE: `cmd_ready` = 1.
  - ISSUE: `tp_start` = 1, exactly one cycle.
  - WAIT: waiting for the tile done event.
  - FINISH: `done_irq` = 1, exactly one cycle.
- Accept is `cmd_valid & cmd_ready` at a clock edge. On accept:
  - latch op and dimensions;
  - set `tp_tile_i` = 0, `tp_tile_j` = 0;
  - clear `tiles_done`, `status` and the abort-pending flag;
  - go to ISSUE, or to FINISH with `status` = 2 if `cmd_op` > 4.
- ISSUE -> WAIT unconditionally. Entering WAIT clears the watchdog counter.
- Done event: `tp_done` = 1 while the registered previous `tp_done_q` = 0, detected in WAIT only. `tp_done_q` updates every cycle in every state.
- On a done event in WAIT:
  - `tiles_done` increments.
  - If the last tile completed: `status` = 0, go to FINISH.
  - Else if abort is pending: `status` = 3, go to FINISH.
  - Else advance the indices and go to ISSUE. Advance order: `tp_tile_j` increments; at `cols_m1` it wraps to 0 and `tp_tile_i` increments.
- Watchdog: the counter increments on each WAIT cycle without a done event. When it reaches `TIMEOUT_CYCLES`: `status` = 1, go to FINISH; remaining tiles are skipped.
- `cmd_abort` is sampled in ISSUE and WAIT and sets abort-pending. It is ignored in IDLE and FINISH.
- `tp_tile_i`, `tp_tile_j` and `tp_op_code` are registers and stay stable from ISSUE until the next index update.
- `cmd_valid` while busy is ignored; no queuing.

## Timing
- Reset values: `cmd_ready` 1, `busy` 0, `tp_start` 0, `tp_tile_i` 0, `tp_tile_j` 0, `tp_op_code` 0, `done_irq` 0, `status` 0, `tiles_done` 0; state IDLE; `tp_done_q` 0; watchdog counter 0.
- Accept at edge E0: `tp_start` is high in cycle E0..E1; state is WAIT from E1.
- Done rising sampled at edge Ed: the next `tp_start` is high in cycle Ed..Ed+1, carrying the new indices. Overhead is 2 cycles per tile beyond the tile processor's own latency.
- FINISH lasts one cycle; IDLE and `cmd_ready` = 1 follow.
- Bad op: `done_irq` is high in the cycle right after the accept edge; no `tp_start` is issued.
- Simultaneous done event and watchdog expiry: done wins.
- Simultaneous done event on the last tile and abort: `status` = 0.
- A `tp_done` level held high across a new start produces no event. The responder must drop `tp_done` before completing the next tile; otherwise that tile times out.
- Reset mid-operation drops every output to its reset value immediately; no `done_irq` is generated.
- Watchdog width is clog2(`TIMEOUT_CYCLES` + 1).

## Structure
- Shared package `npu_pkg`:
  - op-code constants MUL/ADD/SUB/CONV/DOT;
  - `sched_status_t` (OK/TIMEOUT/BAD_OP/ABORTED);
  - `sched_state_t` (IDLE/ISSUE/WAIT/FINISH).
- One sub-module: `watchdog_counter`, parameterized by limit, with clear/enable inputs and an expired output. Everything else stays in `tile_scheduler`.

## Test plan
- 2x2 MUL; the responder raises `tp_done` 10 cycles after each start and drops it on the next start:
  - 4 start pulses with (i,j) = (0,0), (0,1), (1,0), (1,1);
  - `tiles_done` = 4, `status` = 0, one `done_irq`;
  - `cmd_ready` returns high the cycle after `done_irq`.
- `cmd_op` = 5, any dims: `done_irq` in the cycle after accept, `status` = 2, `tiles_done` = 0, no `tp_start`.
- `TIMEOUT_CYCLES` = 32, 1x3 ADD, the responder never completes tile (0,1):
  - `status` = 1 and `tiles_done` = 1;
  - `done_irq` 32 cycles after WAIT entry for the second tile;
  - no third start.
- 3x3 CONV with `cmd_abort` pulsed during the WAIT of tile (0,1): tile (0,1) completes, `tiles_done` = 2, `status` = 3, no further start.
- Sticky `tp_done` held at 1 from the first completion, `TIMEOUT_CYCLES` = 16, 1x2 DOT: the second tile times out with `status` = 1 and `tiles_done` = 1.
- `rst_n` asserted mid-WAIT of a 4x4 MUL: all outputs read reset values immediately, no `done_irq`; a new command after release runs from (0,0).

Source files
------------

// File: rtl/npu_pkg.sv
// npu_pkg: shared tile-scheduler op codes, status codes and FSM state encoding.
package npu_pkg;
   localparam logic [2:0] OP_MUL  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_CONV = 3'd3;
   localparam logic [2:0] OP_DOT  = 3'd4;
   typedef enum logic [1:0] {ST_OK, ST_TIMEOUT, ST_BAD_OP, ST_ABORTED} sched_status_t;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} sched_state_t;
endpackage

// File: rtl/watchdog_counter.sv
// watchdog_counter: per-tile wait-cycle counter with an expiry flag.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (held while issuing a tile)
//   enable     : count this cycle (a wait cycle with no done event)
//   expired    : this enabled cycle is the LIMIT-th, so the tile has timed out
module watchdog_counter #(
   parameter int LIMIT = 4096
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   localparam logic [W-1:0] LIMIT_M1 = W'(LIMIT - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else if (clear) cnt <= '0;
      else if (enable) cnt <= cnt + W'(1);
   // Expiry is flagged on the cycle the count reaches LIMIT, so a tile gets exactly LIMIT wait cycles.
   assign expired = enable && cnt == LIMIT_M1;
endmodule

// File: rtl/tile_scheduler.sv
// tile_scheduler: walks a tile grid row-major, handshaking each tile with the tile processor.
//   cmd_valid/cmd_ready, cmd_op, cmd_rows_m1, cmd_cols_m1 : host command accept
//   cmd_abort  : stop after the current tile
//   tp_start, tp_tile_i, tp_tile_j, tp_op_code, tp_done : tile processor handshake
//   busy, done_irq, status, tiles_done : progress and completion report
module tile_scheduler
   import npu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [2:0] cmd_op,
   input  logic [2:0] cmd_rows_m1,
   input  logic [2:0] cmd_cols_m1,
   input  logic       cmd_abort,
   output logic       tp_start,
   output logic [2:0] tp_tile_i,
   output logic [2:0] tp_tile_j,
   output logic [2:0] tp_op_code,
   input  logic       tp_done,
   output logic       busy,
   output logic       done_irq,
   output logic [1:0] status,
   output logic [6:0] tiles_done
);
   sched_state_t  state, state_n;
   sched_status_t status_q;
   logic [2:0] rows_q, cols_q;
   logic abort_q, tp_done_q, done_ev, last, accept, bad, expired;
   assign cmd_ready = state == S_IDLE;
   assign busy      = state != S_IDLE;
   assign tp_start  = state == S_ISSUE;
   assign done_irq  = state == S_FINISH;
   assign status    = status_q;
   assign accept    = cmd_valid && state == S_IDLE;
   assign bad       = cmd_op > OP_DOT;
   // Only a rising edge of the done level counts, so a level left high across a new start is ignored.
   assign done_ev   = state == S_WAIT && tp_done && !tp_done_q;
   assign last      = tp_tile_i == rows_q && tp_tile_j == cols_q;
   watchdog_counter #(.LIMIT(TIMEOUT_CYCLES)) u_wd (
      .clk(clk),
      .rst_n(rst_n),
      .clear(state == S_ISSUE),
      .enable(state == S_WAIT && !done_ev),
      .expired(expired)
   );
   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:   state_n = accept ? (bad ? S_FINISH : S_ISSUE) : S_IDLE;
         S_ISSUE:  state_n = S_WAIT;
         S_WAIT:   state_n = done_ev ? ((last || abort_q) ? S_FINISH : S_ISSUE) : (expired ? S_FINISH : S_WAIT);
         S_FINISH: state_n = S_IDLE;
         default:  state_n = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state      <= S_IDLE;
         status_q   <= ST_OK;
         rows_q     <= '0;
         cols_q     <= '0;
         abort_q    <= 1'b0;
         tp_done_q  <= 1'b0;
         tp_tile_i  <= '0;
         tp_tile_j  <= '0;
         tp_op_code <= '0;
         tiles_done <= '0;
      end else begin
         state     <= state_n;
         tp_done_q <= tp_done;
         if (accept) begin
            tp_op_code <= cmd_op;
            rows_q     <= cmd_rows_m1;
            cols_q     <= cmd_cols_m1;
            tp_tile_i  <= '0;
            tp_tile_j  <= '0;
            tiles_done <= '0;
            abort_q    <= 1'b0;
            status_q   <= bad ? ST_BAD_OP : ST_OK;
         end else begin
            if ((state == S_ISSUE || state == S_WAIT) && cmd_abort) abort_q <= 1'b1;
            if (done_ev) begin
               tiles_done <= tiles_done + 7'd1;
               if (last) status_q <= ST_OK;
               else if (abort_q) status_q <= ST_ABORTED;
               else begin
                  tp_tile_j <= tp_tile_j == cols_q ? 3'd0 : tp_tile_j + 3'd1;
                  tp_tile_i <= tp_tile_j == cols_q ? tp_tile_i + 3'd1 : tp_tile_i;
               end
            end else if (expired) status_q <= ST_TIMEOUT;
         end
      end
endmodule

// File: tb/tb_tile_scheduler.sv
// tb_tile_scheduler: scoreboard bench for tile_scheduler with a scripted tile-processor responder.
module tb_tile_scheduler;
   import npu_pkg::*;
   localparam logic [21:0] RST_VEC = 22'h200000;
   logic clk = 0, rst_n = 0, cmd_valid = 0, cmd_abort = 0, tp_done = 0;
   logic [2:0] cmd_op = 0, cmd_rows_m1 = 0, cmd_cols_m1 = 0;
   logic cmd_ready, tp_start, busy, done_irq;
   logic [2:0] tp_tile_i, tp_tile_j, tp_op_code;
   logic [1:0] status;
   logic [6:0] tiles_done;
   logic cmd_ready_b, tp_start_b, busy_b, done_irq_b;
   logic [2:0] tp_tile_i_b, tp_tile_j_b, tp_op_code_b;
   logic [1:0] status_b;
   logic [6:0] tiles_done_b;
   int errors = 0, checks = 0, cyc = 0, start_cnt = 0, irq_cnt = 0, last_start_cyc = 0, irq_cyc = 0;
   bit sticky = 0, skip_en = 0;
   logic [2:0] skip_i = 0, skip_j = 0;
   logic [8:0] exp_start[$];
   logic [8:0] exp_done[$];
   tile_scheduler #(.TIMEOUT_CYCLES(32)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_rows_m1(cmd_rows_m1), .cmd_cols_m1(cmd_cols_m1), .cmd_abort(cmd_abort),
      .tp_start(tp_start), .tp_tile_i(tp_tile_i), .tp_tile_j(tp_tile_j), .tp_op_code(tp_op_code),
      .tp_done(tp_done), .busy(busy), .done_irq(done_irq), .status(status), .tiles_done(tiles_done)
   );
   tile_scheduler #(.TIMEOUT_CYCLES(16)) dut16 (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready_b), .cmd_op(cmd_op),
      .cmd_rows_m1(cmd_rows_m1), .cmd_cols_m1(cmd_cols_m1), .cmd_abort(cmd_abort),
      .tp_start(tp_start_b), .tp_tile_i(tp_tile_i_b), .tp_tile_j(tp_tile_j_b), .tp_op_code(tp_op_code_b),
      .tp_done(tp_done), .busy(busy_b), .done_irq(done_irq_b), .status(status_b), .tiles_done(tiles_done_b)
   );
   initial forever #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   function automatic logic [21:0] ovec();
      return {cmd_ready, busy, tp_start, tp_tile_i, tp_tile_j, tp_op_code, done_irq, status, tiles_done};
   endfunction
   function automatic logic [21:0] ovec_b();
      return {cmd_ready_b, busy_b, tp_start_b, tp_tile_i_b, tp_tile_j_b, tp_op_code_b, done_irq_b, status_b, tiles_done_b};
   endfunction
   // Scoreboard consumer plus responder: raises tp_done 10 cycles after each start, drops it on the next start.
   task automatic monitor();
      int cnt = 0;
      bit armed = 0;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            armed = 0;
            tp_done = 0;
         end else if (tp_start) begin
            start_cnt++;
            last_start_cyc = cyc;
            checks++;
            if (exp_start.size() == 0) begin
               errors++;
               $display("FAIL start_unexpected: got op %0d tile (%0d,%0d), required no start", tp_op_code, tp_tile_i, tp_tile_j);
            end else begin
               e = exp_start.pop_front();
               if ({tp_op_code, tp_tile_i, tp_tile_j} !== e) begin
                  errors++;
                  $display("FAIL start_tile: got op %0d tile (%0d,%0d), required op %0d tile (%0d,%0d)",
                           tp_op_code, tp_tile_i, tp_tile_j, e[8:6], e[5:3], e[2:0]);
               end
            end
            if (!sticky) tp_done = 0;
            cnt = 10;
            armed = !(skip_en && tp_tile_i == skip_i && tp_tile_j == skip_j);
         end else if (armed) begin
            cnt--;
            if (cnt == 0) begin
               tp_done = 1;
               armed = 0;
            end
         end else if (cmd_ready && !sticky) tp_done = 0;
         if (rst_n && done_irq) begin
            irq_cnt++;
            irq_cyc = cyc;
            checks++;
            if (exp_done.size() == 0) begin
               errors++;
               $display("FAIL irq_unexpected: got status %0d tiles %0d, required no done_irq", status, tiles_done);
            end else begin
               e = exp_done.pop_front();
               if ({status, tiles_done} !== e) begin
                  errors++;
                  $display("FAIL irq_result: got status %0d tiles %0d, required status %0d tiles %0d",
                           status, tiles_done, e[8:7], e[6:0]);
               end
            end
         end
      end
   endtask
   task automatic send(input logic [2:0] op, input logic [2:0] r, input logic [2:0] c);
      @(negedge clk);
      cmd_op = op;
      cmd_rows_m1 = r;
      cmd_cols_m1 = c;
      cmd_valid = 1;
      @(negedge clk);
      cmd_valid = 0;
   endtask
   task automatic wait_idle(input string name);
      int t = 0;
      while (!(cmd_ready && cmd_ready_b) && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (!(cmd_ready && cmd_ready_b)) begin
         errors++;
         $display("FAIL %s_idle: got cmd_ready %b/%b, required 1/1", name, cmd_ready, cmd_ready_b);
      end
   endtask
   task automatic wait_irq(input int target, input string name);
      int t = 0;
      while (irq_cnt < target && t < 600) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (irq_cnt < target) begin
         errors++;
         $display("FAIL %s_irq: got %0d interrupts, required %0d", name, irq_cnt, target);
      end
   endtask
   task automatic drain(input string name);
      repeat (4) @(negedge clk);
      checks++;
      if (exp_start.size() != 0 || exp_done.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d starts and %0d irqs outstanding, required 0 and 0", name, exp_start.size(), exp_done.size());
      end
      exp_start.delete();
      exp_done.delete();
   endtask
   task automatic test_reset();
      #1;
      checks++;
      if (ovec() !== RST_VEC) begin
         errors++;
         $display("FAIL reset_in: got %h, required %h", ovec(), RST_VEC);
      end
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (2) @(negedge clk);
      checks++;
      if (ovec() !== RST_VEC || ovec_b() !== RST_VEC) begin
         errors++;
         $display("FAIL reset_out: got %h/%h, required %h", ovec(), ovec_b(), RST_VEC);
      end
   endtask
   task automatic test_mul_2x2();
      int s0 = start_cnt;
      wait_idle("mul");
      exp_start.push_back({OP_MUL, 3'd0, 3'd0});
      exp_start.push_back({OP_MUL, 3'd0, 3'd1});
      exp_start.push_back({OP_MUL, 3'd1, 3'd0});
      exp_start.push_back({OP_MUL, 3'd1, 3'd1});
      exp_done.push_back({2'd0, 7'd4});
      send(OP_MUL, 3'd1, 3'd1);
      wait_irq(irq_cnt + 1, "mul");
      while (cyc <= irq_cyc) @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1 || done_irq !== 1'b0 || cyc != irq_cyc + 1) begin
         errors++;
         $display("FAIL mul_ready_after_irq: got ready %b irq %b at +%0d, required ready 1 irq 0 at +1", cmd_ready, done_irq, cyc - irq_cyc);
      end
      checks++;
      if (start_cnt - s0 != 4) begin
         errors++;
         $display("FAIL mul_starts: got %0d, required 4", start_cnt - s0);
      end
      drain("mul");
   endtask
   task automatic test_bad_op();
      int s0 = start_cnt;
      wait_idle("badop");
      exp_done.push_back({2'd2, 7'd0});
      send(3'd5, 3'd2, 3'd3);
      checks++;
      if ({done_irq, tp_start, status, tiles_done} !== {1'b1, 1'b0, 2'd2, 7'd0}) begin
         errors++;
         $display("FAIL badop_irq: got irq %b start %b status %0d tiles %0d, required 1 0 2 0", done_irq, tp_start, status, tiles_done);
      end
      drain("badop");
      checks++;
      if (start_cnt != s0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL badop_nostart: got %0d starts ready %b, required 0 starts ready 1", start_cnt - s0, cmd_ready);
      end
   endtask
   task automatic test_timeout();
      wait_idle("timeout");
      skip_en = 1;
      skip_i = 0;
      skip_j = 1;
      exp_start.push_back({OP_ADD, 3'd0, 3'd0});
      exp_start.push_back({OP_ADD, 3'd0, 3'd1});
      exp_done.push_back({2'd1, 7'd1});
      send(OP_ADD, 3'd0, 3'd2);
      wait_irq(irq_cnt + 1, "timeout");
      checks++;
      if (irq_cyc - last_start_cyc != 33) begin
         errors++;
         $display("FAIL timeout_latency: got irq %0d cycles after WAIT entry, required 32", irq_cyc - last_start_cyc - 1);
      end
      drain("timeout");
      skip_en = 0;
   endtask
   task automatic test_abort();
      int s0 = start_cnt, t = 0;
      wait_idle("abort");
      exp_start.push_back({OP_CONV, 3'd0, 3'd0});
      exp_start.push_back({OP_CONV, 3'd0, 3'd1});
      exp_done.push_back({2'd3, 7'd2});
      send(OP_CONV, 3'd2, 3'd2);
      while (start_cnt < s0 + 2 && t < 200) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      cmd_abort = 1;
      @(negedge clk);
      cmd_abort = 0;
      wait_irq(irq_cnt + 1, "abort");
      drain("abort");
   endtask
   task automatic test_sticky_done();
      int t = 0;
      wait_idle("sticky");
      sticky = 1;
      exp_start.push_back({OP_DOT, 3'd0, 3'd0});
      exp_start.push_back({OP_DOT, 3'd0, 3'd1});
      exp_done.push_back({2'd1, 7'd1});
      send(OP_DOT, 3'd0, 3'd1);
      while (done_irq_b !== 1'b1 && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if ({done_irq_b, status_b, tiles_done_b} !== {1'b1, 2'd1, 7'd1}) begin
         errors++;
         $display("FAIL sticky_t16: got irq %b status %0d tiles %0d, required 1 1 1", done_irq_b, status_b, tiles_done_b);
      end
      wait_irq(irq_cnt + 1, "sticky");
      sticky = 0;
      drain("sticky");
   endtask
   task automatic test_reset_mid();
      int s0 = start_cnt, i0, t = 0;
      wait_idle("rstmid");
      exp_start.push_back({OP_MUL, 3'd0, 3'd0});
      send(OP_MUL, 3'd3, 3'd3);
      while (start_cnt < s0 + 1 && t < 200) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
      i0 = irq_cnt;
      rst_n = 0;
      #1;
      checks++;
      if (ovec() !== RST_VEC) begin
         errors++;
         $display("FAIL rstmid_outputs: got %h, required %h", ovec(), RST_VEC);
      end
      repeat (3) @(negedge clk);
      rst_n = 1;
      repeat (3) @(negedge clk);
      checks++;
      if (irq_cnt != i0 || ovec() !== RST_VEC) begin
         errors++;
         $display("FAIL rstmid_quiet: got %0d irqs outputs %h, required 0 irqs outputs %h", irq_cnt - i0, ovec(), RST_VEC);
      end
      exp_start.push_back({OP_SUB, 3'd0, 3'd0});
      exp_start.push_back({OP_SUB, 3'd0, 3'd1});
      exp_done.push_back({2'd0, 7'd2});
      send(OP_SUB, 3'd0, 3'd1);
      wait_irq(irq_cnt + 1, "rstmid_rerun");
      drain("rstmid");
   endtask
   initial begin
      fork
         monitor();
      join_none
      test_reset();
      test_mul_2x2();
      test_bad_op();
      test_timeout();
      test_abort();
      test_sticky_done();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
